// File: rtl/uart_tx_dev_pkg.sv
// Shared register offsets, FSM encoding and baud helper for the memory-mapped UART transmitter.
package uart_tx_dev_pkg;

    localparam logic [1:0] UART_CTRL   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DATA   = 2'd2;
    localparam logic [1:0] UART_DIV    = 2'd3;

    localparam int CTRL_TXEN  = 0;
    localparam int CTRL_IRQEN = 1;

    typedef enum logic [1:0] {
        UART_IDLE   = 2'd0,
        UART_START  = 2'd1,
        UART_DATA_S = 2'd2,
        UART_STOP   = 2'd3
    } uart_state_e;

    // Last baud-counter value of a bit; a zero divisor behaves like a divisor of one.
    function automatic logic [15:0] last_tick(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO feeding the UART serialiser; a push while full is accepted only if a pop happens too.
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage carries no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Bridge-attached UART transmitter: register file, 8N1 baud FSM and level IRQ on drained idle line.
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h0000_7F20,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] RD,
    output logic        IRQ,
    output logic        tx
);
    logic [1:0]             ctrl;
    logic [15:0]            divisor;
    logic                   ovf;
    uart_state_e            state;
    logic [7:0]             shreg;
    logic [2:0]             bitidx;
    logic [15:0]            cnt;

    logic                   sel;
    logic [1:0]             off;
    logic                   wr;
    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic [7:0]             fifo_dout;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   unused_bits;

    assign sel     = (addr[31:4] == BASE[31:4]);
    assign off     = addr[3:2];
    assign wr      = we && sel;
    assign push    = wr && (off == UART_DATA) && be[0];
    assign pop     = (state == UART_IDLE) && ctrl[CTRL_TXEN] && !empty;
    assign bit_end = (cnt >= last_tick(divisor));

    assign unused_bits = ^{wd[31:16], be[3:2], addr[1:0]};

    uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (wd[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= '0;
            divisor <= DIV_RESET;
            ovf     <= 1'b0;
        end else begin
            if (wr && off == UART_CTRL && be[0]) ctrl <= wd[1:0];
            if (wr && off == UART_DIV) begin
                if (be[0]) divisor[7:0]  <= wd[7:0];
                if (be[1]) divisor[15:8] <= wd[15:8];
            end
            // A push onto a full FIFO is lost unless the serialiser pops in the same cycle.
            if (wr && off == UART_STATUS && be[0]) ovf <= 1'b0;
            else if (push && full && !pop)         ovf <= 1'b1;
        end
    end

    // NOTE: all FSM state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= UART_IDLE;
            shreg  <= '0;
            bitidx <= '0;
            cnt    <= '0;
            tx     <= 1'b1;
            IRQ    <= 1'b0;
        end else begin
            IRQ <= ctrl[CTRL_IRQEN] && empty && (state == UART_IDLE);
            case (state)
                UART_IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        shreg <= fifo_dout;
                        tx    <= 1'b0;
                        state <= UART_START;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                UART_START: begin
                    if (bit_end) begin
                        tx     <= shreg[0];
                        bitidx <= '0;
                        cnt    <= '0;
                        state  <= UART_DATA_S;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                UART_DATA_S: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bitidx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= UART_STOP;
                        end else begin
                            shreg  <= shreg >> 1;
                            tx     <= shreg[1];
                            bitidx <= bitidx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                UART_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= UART_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

    // NOTE: RD gets a default before the case so no path through the block can infer a latch.
    always_comb begin
        RD = '0;
        case (off)
            UART_CTRL:   RD = {30'd0, ctrl};
            UART_STATUS: RD = {24'd0, 4'(count), ovf, empty, full, state != UART_IDLE};
            UART_DIV:    RD = {16'd0, divisor};
            default:     RD = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: expected tx samples are queued as bytes are written and popped per cycle.
module tb_uart_tx_dev;

    localparam logic [31:0] BASE = 32'h0000_7F20;
    localparam logic [1:0]  O_CTRL = 2'd0, O_STATUS = 2'd1, O_DATA = 2'd2, O_DIV = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] RD;
    logic        IRQ;
    logic        tx;

    int   n_checks = 0;
    int   n_fails  = 0;
    logic exp_q[$];

    uart_tx_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wd    (wd),
        .RD    (RD),
        .IRQ   (IRQ),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; compares tx against the scoreboard whenever a sample is pending.
    task automatic step();
        logic e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx_stream", {31'd0, tx}, {31'd0, e});
        end
    endtask

    task automatic bus_write(input logic [1:0] o, input logic [31:0] data, input logic [3:0] mask);
        addr = BASE + {28'd0, o, 2'b00};
        wd   = data;
        be   = mask;
        we   = 1'b1;
        step();
        we   = 1'b0;
        be   = 4'h0;
        addr = BASE + 32'h4;
    endtask

    task automatic read_check(input string tag, input logic [1:0] o, input logic [31:0] exp);
        addr = BASE + {28'd0, o, 2'b00};
        #1;
        check(tag, RD, exp);
        addr = BASE + 32'h4;
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endtask

    task automatic expect_frame(input logic [7:0] b, input int p);
        for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < p; k++) exp_q.push_back(b[j]);
        for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        reset = 1'b1;
        we    = 1'b0;
        be    = 4'h0;
        wd    = '0;
        addr  = BASE + 32'h4;
        repeat (3) @(posedge clk);
        #1;
        check("tx_in_reset", {31'd0, tx}, 32'd1);
        check("irq_in_reset", {31'd0, IRQ}, 32'd0);
        reset = 1'b0;

        // Reset state of the register map.
        read_check("rst_ctrl", O_CTRL, 32'h0);
        read_check("rst_status", O_STATUS, 32'h04);
        read_check("rst_data", O_DATA, 32'h0);
        read_check("rst_div", O_DIV, 32'h4);

        // Byte-lane divisor writes, then one 0xA5 frame at two cycles per bit.
        bus_write(O_DIV, 32'hFFFF_12AB, 4'b0010);
        read_check("div_byte1", O_DIV, 32'h1204);
        bus_write(O_DIV, 32'h0000_0002, 4'b0011);
        read_check("div_set2", O_DIV, 32'h2);
        bus_write(O_CTRL, 32'hFFFF_FFFD, 4'b0001);
        read_check("ctrl_mask", O_CTRL, 32'h1);
        expect_idle(1);
        expect_frame(8'hA5, 2);
        expect_idle(2);
        bus_write(O_DATA, 32'h0000_00A5, 4'b0001);
        repeat (5) step();
        read_check("busy_mid_frame", O_STATUS, 32'h05);
        drain();
        read_check("idle_after_a5", O_STATUS, 32'h04);

        // Fill past capacity with the transmitter disabled.
        bus_write(O_CTRL, 32'h0, 4'b0001);
        for (int i = 1; i <= 5; i++) bus_write(O_DATA, 32'(8'h11 * i), 4'b0001);
        read_check("full_ovf", O_STATUS, 32'h4A);
        bus_write(O_STATUS, 32'h0, 4'b0001);
        read_check("ovf_cleared", O_STATUS, 32'h42);

        // Drain the four held bytes at one cycle per bit; the overflowed 0x55 must never appear.
        bus_write(O_DIV, 32'h1, 4'b0011);
        expect_idle(1);
        for (int i = 1; i <= 4; i++) begin
            b = 8'(8'h11 * i);
            expect_frame(b, 1);
            expect_idle(1);
        end
        expect_idle(3);
        bus_write(O_CTRL, 32'h1, 4'b0001);
        drain();
        read_check("drained", O_STATUS, 32'h04);
        check("irq_disabled", {31'd0, IRQ}, 32'd0);

        // IRQ timing around enable, pushes, frame completion and disable.
        bus_write(O_CTRL, 32'h3, 4'b0001);
        check("irq_lag", {31'd0, IRQ}, 32'd0);
        step();
        check("irq_rise", {31'd0, IRQ}, 32'd1);
        expect_idle(1);
        expect_frame(8'h00, 1);
        expect_idle(1);
        expect_frame(8'hFF, 1);
        bus_write(O_DATA, 32'h00, 4'b0001);
        check("irq_push_edge", {31'd0, IRQ}, 32'd1);
        bus_write(O_DATA, 32'hFF, 4'b0001);
        check("irq_push_drop", {31'd0, IRQ}, 32'd0);
        drain();
        step();
        check("irq_after_stop", {31'd0, IRQ}, 32'd0);
        check("tx_idle_after_pair", {31'd0, tx}, 32'd1);
        step();
        check("irq_drained", {31'd0, IRQ}, 32'd1);
        bus_write(O_CTRL, 32'h1, 4'b0001);
        check("irq_irqen_edge", {31'd0, IRQ}, 32'd1);
        step();
        check("irq_irqen_clear", {31'd0, IRQ}, 32'd0);

        // Shorten the divisor from 8 to 3 while the start bit counter sits at 5.
        bus_write(O_DIV, 32'h8, 4'b0011);
        b = 8'h96;
        expect_idle(1);
        for (int k = 0; k < 7; k++) exp_q.push_back(1'b0);
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 3; k++) exp_q.push_back(b[j]);
        for (int k = 0; k < 3; k++) exp_q.push_back(1'b1);
        expect_idle(1);
        bus_write(O_DATA, 32'h96, 4'b0001);
        repeat (6) step();
        bus_write(O_DIV, 32'h3, 4'b0011);
        drain();
        read_check("div_live", O_DIV, 32'h3);

        // Reset in the middle of a data bit with two bytes still queued.
        bus_write(O_DATA, 32'h00, 4'b0001);
        bus_write(O_DATA, 32'h12, 4'b0001);
        bus_write(O_DATA, 32'h34, 4'b0001);
        repeat (6) step();
        check("tx_data_low", {31'd0, tx}, 32'd0);
        read_check("busy_two_queued", O_STATUS, 32'h21);
        reset = 1'b1;
        #1;
        check("tx_async_reset", {31'd0, tx}, 32'd1);
        read_check("status_async_reset", O_STATUS, 32'h04);
        read_check("div_async_reset", O_DIV, 32'h4);
        step();
        reset = 1'b0;
        bus_write(O_CTRL, 32'h1, 4'b0001);
        expect_idle(8);
        drain();
        read_check("no_frame_after_reset", O_STATUS, 32'h04);
        expect_idle(1);
        expect_frame(8'h81, 4);
        expect_idle(2);
        bus_write(O_DATA, 32'h81, 4'b0001);
        drain();
        read_check("final_status", O_STATUS, 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
- Memory-mapped UART transmitter, attached to the Bridge as a third peripheral alongside the two TC timers.
- The core writes bytes into a small FIFO; a baud-rate state machine serialises them 8N1 on `tx`.
- Raises a level IRQ when the FIFO has drained and the line is idle; the IRQ feeds one HWInt bit.
- Clocked on the same inverted clock the top drives into memory and the TCs.

Parameters:
- BASE, 32'h0000_7F20: device base address; block decodes BASE..BASE+0xF.
- DEPTH, 4: FIFO depth in bytes; power of two, ≥2.
- DIV_RESET, 16'd4: reset value of the DIVISOR register.

Ports:
- clk  input  1  device clock (inverted core clock from top)
- reset  input  1  asynchronous, active-high reset
- addr  input  32  bus address from Bridge
- we  input  1  write enable, already gated by Bridge decode
- be  input  4  byte enables
- wd  input  32  write data
- RD  output  32  read data, combinational on addr
- IRQ  output  1  interrupt request, level
- tx  output  1  serial line, idle high

Behaviour:
- Register map, offset = addr[3:2]; block is selected when addr[31:4]==BASE[31:4]:
  - 0 CTRL (RW): bit0 TXEN, bit1 IRQEN. Written only when be[0]. Other bits read 0.
  - 1 STATUS (RO): bit0 BUSY (state≠IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[7:4] FIFO count. Any write with be[0] clears OVF.
  - 2 DATA (WO): a write with be[0] pushes wd[7:0]. Reads return 0.
  - 3 DIVISOR (RW): bits[15:0], byte-wise via be[1:0]. Bits[31:16] read 0.
- RD = register selected by addr[3:2] regardless of select, 0-extended; the Bridge muxes.
- Reset (async): CTRL=0, DIVISOR=DIV_RESET, FIFO empty, OVF=0, state IDLE, tx=1, IRQ=0, bit counter=0, baud counter=0.
- FIFO:
  - Push when full is dropped and sets OVF; the count is unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged. This applies even when full, so the push is accepted and OVF is not set.
  - Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.
- Bit period P = DIVISOR, with DIVISOR==0 treated as 1.
  - Baud counter counts 0..P-1; a bit ends when cnt ≥ P-1.
  - The compare is against the live DIVISOR, so a mid-frame write takes effect on the current bit without hanging.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: at an edge with TXEN && !EMPTY → pop, shreg←byte, cnt←0, tx←0, go to START. Otherwise tx=1.
  - START: at bit end → tx←shreg[0], bitidx←0, cnt←0, go to DATA.
  - DATA: at bit end → if bitidx==7 then tx←1, go to STOP; else shift shreg right, tx←next bit, bitidx+1. cnt←0.
  - STOP: at bit end → IDLE.
- A frame is exactly 10·P cycles of tx. Back-to-back frames have exactly 1 idle-high cycle between them (the IDLE evaluation cycle).
- A push arriving at the same edge while IDLE and EMPTY is not popped until the next edge. tx falls 2 edges after the DATA write.
- Clearing TXEN mid-frame: the current frame completes; no further pops.
- IRQ (registered) = IRQEN && EMPTY && state==IDLE. It updates the cycle after any contributing change and is cleared by a DATA push or by clearing IRQEN.
- Reset mid-frame: tx returns to 1 immediately; FIFO contents are discarded.

Decomposition:
- macro.vh gains:
  - UART offsets (`UART_CTRL`, `UART_STATUS`, `UART_DATA`, `UART_DIV`)
  - 2-bit state encodings (`UART_IDLE`=0, `UART_START`=1, `UART_DATA_S`=2, `UART_STOP`=3)
  - `DEV2ADDR_BEGIN`, for a third Bridge slot
- One sub-module, `uart_fifo`: parameter DEPTH; ports clk, reset, push, din[7:0], pop, dout[7:0], full, empty, count.
- The top-level adds Dev2WE, Dev2RD and Dev2Irq; the Bridge maps Dev2Irq to HWInt[2].

Test Plan:
- Reset, then read all four offsets → CTRL=0, STATUS=0x04 (EMPTY), DIVISOR=4; tx=1, IRQ=0.
- DIV=2, TXEN=1, write DATA=0xA5 → tx falls 2 edges after the write. tx sequence per 2-cycle bit: 0,1,0,1,0,0,1,0,1,1. BUSY=1 during the frame.
- TXEN=0, write 5 bytes with DEPTH=4 → count=4, FULL=1, OVF=1. Write STATUS → OVF=0, count still 4.
- IRQEN=1, TXEN=1, DIV=1, push 0x00 and 0xFF → two 10-cycle frames with a 1-cycle gap. IRQ rises 1 cycle after the second STOP completes; a DATA write drops IRQ next cycle.
- DIV=8 mid-bit with cnt=5, then write DIV=3 → the current bit ends at the next edge (cnt ≥ 2); the following bits are 3 cycles each.
- Assert reset during the DATA state with 2 bytes queued → tx=1 immediately, STATUS=0x04; after release no frame is sent until a new push.
